// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux4 arbiter.
// Covers the requester count, select width, FSM states and one-hot grant encoding.
package mux_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux4_1.sv
// Plain 4:1 data multiplexer steered by two select bits; {s1,s0} is the chosen input.
module mux4_1 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_d0,
   input  logic [WIDTH-1:0] i_d1,
   input  logic [WIDTH-1:0] i_d2,
   input  logic [WIDTH-1:0] i_d3,
   input  logic             i_s0,
   input  logic             i_s1,
   output logic [WIDTH-1:0] o_y
);

   always_comb begin
      case ({i_s1, i_s0})
         2'b00:   o_y = i_d0;
         2'b01:   o_y = i_d1;
         2'b10:   o_y = i_d2;
         default: o_y = i_d3;
      endcase
   end

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker.
// Returns the first set request found when searching start, start+1, ... (mod 4).
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [SEL_W-1:0]   i_start,
   output logic [SEL_W-1:0]   o_idx,
   output logic               o_found
);

   logic [SEL_W-1:0] w_cand;

   // Walk from the farthest offset back to start so the nearest hit wins last.
   always_comb begin
      o_found = 1'b0;
      o_idx   = i_start;
      w_cand  = i_start;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_cand = i_start + SEL_W'(k);
         if (i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux among four requesters.
// Registers grant, selects and the selected data; a hold counter bounds ownership under contention.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req,
   input  logic [WIDTH-1:0]   din0,
   input  logic [WIDTH-1:0]   din1,
   input  logic [WIDTH-1:0]   din2,
   input  logic [WIDTH-1:0]   din3,
   output logic [3:0]         gnt,
   output logic               s0,
   output logic               s1,
   output logic [WIDTH-1:0]   dout,
   output logic               dout_valid,
   output arb_state_t         o_dbg_state
);

   // Handshake: a requester keeps req high while it wants the mux; gnt (one-hot or zero)
   // names the owner one clock later, and dout/dout_valid follow gnt by one more clock.
   // Dropping req for a single cycle forfeits the grant.

   localparam int              HW        = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

   arb_state_t         r_state;
   logic [SEL_W-1:0]   r_ptr;
   logic [SEL_W-1:0]   r_sel;
   logic [3:0]         r_gnt;
   logic [HW-1:0]      r_hold;
   logic [WIDTH-1:0]   r_dout;
   logic               r_dout_valid;

   arb_state_t         w_nxt_state;
   logic [SEL_W-1:0]   w_nxt_ptr;
   logic [SEL_W-1:0]   w_nxt_sel;
   logic [3:0]         w_nxt_gnt;
   logic [HW-1:0]      w_nxt_hold;
   logic [WIDTH-1:0]   w_nxt_dout;
   logic               w_nxt_valid;

   logic [WIDTH-1:0]   w_mux_y;
   logic [SEL_W-1:0]   w_idle_idx;
   logic               w_idle_found;
   logic [3:0]         w_rel_req;
   logic [SEL_W-1:0]   w_rel_start;
   logic [SEL_W-1:0]   w_rel_idx;
   logic               w_rel_found;
   logic               w_expired;

   mux4_1 #(.WIDTH(WIDTH)) u_mux (
      .i_d0 (din0),
      .i_d1 (din1),
      .i_d2 (din2),
      .i_d3 (din3),
      .i_s0 (r_sel[0]),
      .i_s1 (r_sel[1]),
      .o_y  (w_mux_y)
   );

   rr_pick4 u_pick_idle (
      .i_req   (req),
      .i_start (r_ptr),
      .o_idx   (w_idle_idx),
      .o_found (w_idle_found)
   );

   // Hand-off path: everyone except the current owner, searched from the owner's successor.
   assign w_rel_req   = req & ~onehot4(r_sel);
   assign w_rel_start = r_sel + 2'd1;
   assign w_expired   = (r_hold == HOLD_LAST) && (w_rel_req != 4'd0);

   rr_pick4 u_pick_rel (
      .i_req   (w_rel_req),
      .i_start (w_rel_start),
      .o_idx   (w_rel_idx),
      .o_found (w_rel_found)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ptr   = r_ptr;
      w_nxt_sel   = r_sel;
      w_nxt_gnt   = r_gnt;
      w_nxt_hold  = r_hold;
      w_nxt_dout  = r_dout;
      w_nxt_valid = r_dout_valid;
      case (r_state)
         IDLE: begin
            w_nxt_valid = 1'b0;
            if (w_idle_found) begin
               w_nxt_state = GRANT;
               w_nxt_sel   = w_idle_idx;
               w_nxt_gnt   = onehot4(w_idle_idx);
               w_nxt_hold  = '0;
            end
         end
         GRANT: begin
            if (req[r_sel] && !w_expired) begin
               w_nxt_dout  = w_mux_y;
               w_nxt_valid = 1'b1;
               // A lone owner wraps its counter instead of being cut off.
               w_nxt_hold  = (r_hold == HOLD_LAST) ? '0 : r_hold + HW'(1);
            end else begin
               w_nxt_ptr   = w_rel_start;
               w_nxt_valid = 1'b0;
               if (w_rel_found) begin
                  w_nxt_sel  = w_rel_idx;
                  w_nxt_gnt  = onehot4(w_rel_idx);
                  w_nxt_hold = '0;
               end else begin
                  w_nxt_gnt   = 4'd0;
                  w_nxt_state = IDLE;
               end
            end
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_ptr        <= '0;
         r_sel        <= '0;
         r_gnt        <= 4'd0;
         r_hold       <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_ptr        <= w_nxt_ptr;
         r_sel        <= w_nxt_sel;
         r_gnt        <= w_nxt_gnt;
         r_hold       <= w_nxt_hold;
         r_dout       <= w_nxt_dout;
         r_dout_valid <= w_nxt_valid;
      end
   end

   assign gnt         = r_gnt;
   assign s0          = r_sel[0];
   assign s1          = r_sel[1];
   assign dout        = r_dout;
   assign dout_valid  = r_dout_valid;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized bench for mux4_rr_arbiter against an owner/turn-order reference model.
module tb_mux4_rr_arbiter;
   import mux_arb_pkg::*;

   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;
   localparam int WAIT_MAX = 3 * MAX_HOLD + 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       req;
   logic [WIDTH-1:0] din0, din1, din2, din3;
   logic [3:0]       gnt;
   logic             s0, s1;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   arb_state_t       dbg_state;

   int checks = 0;
   int errors = 0;

   // reference model: who owns the mux, whose turn is next, cycles served in this turn
   int               m_owner;
   int               m_ptr;
   int               m_held;
   logic [1:0]       m_sel;
   logic [WIDTH-1:0] m_dout;
   logic             m_valid;
   logic [3:0]       req_pre;
   int               wait_cnt [4];

   mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .din0        (din0),
      .din1        (din1),
      .din2        (din2),
      .din3        (din3),
      .gnt         (gnt),
      .s0          (s0),
      .s1          (s1),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] din_of(input int i);
      case (i)
         0:       return din0;
         1:       return din1;
         2:       return din2;
         default: return din3;
      endcase
   endfunction

   function automatic int search(input logic [3:0] r, input int start);
      for (int k = 0; k < 4; k++)
         if (r[(start + k) % 4]) return (start + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_sel   = 2'd0;
      m_dout  = '0;
      m_valid = 1'b0;
   endtask

   // Advance the model by one clock using the inputs present before the edge.
   task automatic model_edge();
      logic [3:0] others;
      int         w;
      if (m_owner < 0) begin
         m_valid = 1'b0;
         w = search(req, m_ptr);
         if (w >= 0) begin
            m_owner = w;
            m_sel   = 2'(w);
            m_held  = 0;
         end
      end else begin
         others = req & ~(4'b0001 << m_owner);
         if (req[m_owner] && !(m_held == MAX_HOLD - 1 && others != 4'd0)) begin
            m_dout  = din_of(m_owner);
            m_valid = 1'b1;
            m_held  = (m_held + 1) % MAX_HOLD;
         end else begin
            m_ptr   = (m_owner + 1) % 4;
            m_valid = 1'b0;
            w       = search(others, m_ptr);
            m_owner = w;
            if (w >= 0) begin
               m_sel  = 2'(w);
               m_held = 0;
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic [3:0] exp_gnt;
      exp_gnt = (m_owner < 0) ? 4'd0 : (4'b0001 << m_owner);
      check({tag, "_gnt"},   gnt,        exp_gnt);
      check({tag, "_sel"},   {s1, s0},   m_sel);
      check({tag, "_dout"},  dout,       m_dout);
      check({tag, "_valid"}, dout_valid, m_valid);
   endtask

   task automatic cycle(input string tag);
      model_edge();
      req_pre = req;
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int max_wait;
      rst  = 1'b1;
      req  = 4'd0;
      din0 = '0; din1 = '0; din2 = '0; din3 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_gnt",   gnt,        4'd0);
      check("reset_sel",   {s1, s0},   2'd0);
      check("reset_dout",  dout,       8'd0);
      check("reset_valid", dout_valid, 1'b0);
      check("reset_state", dbg_state,  IDLE);
      rst = 1'b0;

      // single request, first data after one more edge
      req  = 4'b0100;
      din2 = 8'hA5;
      cycle("t1a");
      check("t1_gnt", gnt, 4'b0100);
      check("t1_sel", {s1, s0}, 2'b10);
      cycle("t1b");
      check("t1_dout",  dout, 8'hA5);
      check("t1_valid", dout_valid, 1'b1);

      // all requesting: each owner gets exactly MAX_HOLD cycles, in order 0,1,2,3,0
      do_reset();
      req = 4'b1111;
      for (int j = 0; j < 5 * MAX_HOLD; j++) begin
         din0 = 8'($urandom); din1 = 8'($urandom); din2 = 8'($urandom); din3 = 8'($urandom);
         cycle("t2");
         check("t2_order", gnt, 4'b0001 << ((j / MAX_HOLD) % 4));
      end

      // sole requester keeps the mux past the hold limit
      req = 4'b0010;
      for (int j = 0; j < 11; j++) begin
         din1 = 8'($urandom);
         cycle("t3");
         check("t3_sole_gnt", gnt, 4'b0010);
      end
      req = 4'b0000;
      cycle("t3_drop");
      check("t3_drop_gnt", gnt, 4'd0);
      check("t3_state", dbg_state, IDLE);

      // owner 3 drops while requester 0 raises on the same edge
      req = 4'b1000;
      cycle("t4a");
      check("t4_gnt3", gnt, 4'b1000);
      cycle("t4b");
      req = 4'b0001;
      cycle("t4c");
      check("t4_wrap_gnt", gnt, 4'b0001);

      // asynchronous reset in the middle of a grant
      do_reset();
      req  = 4'b0100;
      din2 = 8'h3C;
      cycle("t5a");
      cycle("t5b");
      check("t5_pre_gnt", gnt, 4'b0100);
      rst = 1'b1;
      #2;
      check("t5_async_gnt",   gnt,        4'd0);
      check("t5_async_s0",    s0,         1'b0);
      check("t5_async_s1",    s1,         1'b0);
      check("t5_async_dout",  dout,       8'd0);
      check("t5_async_valid", dout_valid, 1'b0);
      model_reset();
      req = 4'b1010;
      #1;
      rst = 1'b0;
      cycle("t5c");
      check("t5_first_gnt", gnt, 4'b0010);

      // randomized traffic with sticky requests
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      for (int n = 0; n < 1000; n++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
         din0 = 8'($urandom); din1 = 8'($urandom); din2 = 8'($urandom); din3 = 8'($urandom);
         cycle("rnd");
         check("rnd_onehot0", 32'($onehot0(gnt)), 32'd1);
         if (gnt != 4'd0) check("rnd_sel_match", gnt, 4'b0001 << {s1, s0});
         max_wait = 0;
         for (int i = 0; i < 4; i++) begin
            if (req_pre[i] && !gnt[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
         end
         check("rnd_wait_bound", 32'(max_wait <= WAIT_MAX), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 4:1 multiplexer datapath (mux4_1) between four requesters.
- Each requester raises a request. The block grants one requester at a time and drives the mux selects s0/s1 to match.
- It registers the selected data onto a single output bus with a valid flag.
- A hold counter limits how long one requester can keep the mux while others wait.

Parameters:
- WIDTH, 8, data width of each input and of dout.
- MAX_HOLD, 4, maximum consecutive granted cycles while another request is pending. Legal range 1..255.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  4  request per requester; bit i = requester i.
- din0  in  WIDTH  requester 0 data.
- din1  in  WIDTH  requester 1 data.
- din2  in  WIDTH  requester 2 data.
- din3  in  WIDTH  requester 3 data.
- gnt  out  4  one-hot grant, registered.
- s0  out  1  mux select LSB, registered; {s1,s0} = granted index.
- s1  out  1  mux select MSB, registered.
- dout  out  WIDTH  registered copy of the granted input.
- dout_valid  out  1  dout holds data from an active grant.

Behaviour:
- Reset (asynchronous, any time, including mid-grant):
  - gnt=0, s0=0, s1=0, dout=0, dout_valid=0.
  - state=IDLE, ptr=0, hold_cnt=0.
  - First arbitration after release of rst favours requester 0.
- Internal state:
  - ptr (2 bits): highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
  - idx (2 bits): current grant index.
  - hold_cnt: counts granted cycles, width ceil(log2(MAX_HOLD+1)).
- IDLE:
  - gnt=0. s0/s1 hold their last value and do not toggle with no owner.
  - If req≠0 at edge k: pick the winner by rotating priority. After edge k: gnt=onehot(winner), {s1,s0}=winner, hold_cnt=0, state=GRANT.
  - Grant latency is one clock from request.
- GRANT, evaluated each edge:
  - If req[idx]=1 and not expired: dout<=din[idx], dout_valid<=1, hold_cnt++.
  - Expired means hold_cnt==MAX_HOLD-1 and (req with bit idx masked)≠0.
- Release, when req[idx]=0 or the grant has expired:
  - ptr<=idx+1 mod 4.
  - Re-arbitrate on the same edge among req with bit idx masked, searching from idx+1. There is no bubble cycle between owners.
  - If a winner is found: new gnt/sel, hold_cnt=0, stay in GRANT.
  - If none: gnt=0, state=IDLE.
  - dout_valid<=0 on a release edge when the new owner's data is not yet captured. dout keeps its last value.
- Data timing: dout lags gnt/sel by one clock. dout_valid=1 exactly on cycles following an edge where the owner's req was high and the owner was retained.
- Sole requester: if hold expires with no other request pending, it keeps the grant. hold_cnt restarts at 0 and does not overflow.
- Simultaneous release and new request on the same edge: the new request participates in that edge's arbitration.
- A requester dropping req for one cycle loses its grant. Re-raising req means waiting its turn.
- Invariants: gnt is always one-hot or zero. {s1,s0} always equals the index of the set gnt bit when gnt≠0.

Decomposition:
- Package mux_arb_pkg holds:
  - NUM_REQ=4 and SEL_W=2.
  - State enum {IDLE, GRANT}.
  - Function onehot4(idx).
- Sub-module rr_pick4 is a combinational rotating-priority picker.
  - Inputs: req[3:0] and start[1:0].
  - Outputs: idx[1:0] and found.
  - It is reused for the IDLE and release paths (the release path uses masked req and start=idx+1).
- Top level instantiates mux4_1 for the data selection, using its s0/s1 interface.

Test Plan:
- Reset then req=4'b0100, din2=8'hA5 → next edge gnt=4'b0100, {s1,s0}=2'b10. Following edge dout=8'hA5, dout_valid=1.
- req=4'b1111 held, MAX_HOLD=4 → grant order 0,1,2,3,0 with each owner held exactly 4 cycles, no idle cycle between owners.
- Requester 1 sole, req held 10 cycles → gnt stays 4'b0010 throughout with no expiry gap. Drop req → next edge gnt=0, state IDLE.
- Owner 3 drops req on the same edge requester 0 raises → next edge gnt=4'b0001 (wrap-around from ptr=0), no bubble.
- Assert rst mid-grant (gnt=4'b0100) between clock edges → gnt, s0, s1, dout, dout_valid go to 0 immediately without a clock edge. After release with req=4'b1010 → requester 1 is granted first.
- Random req/din for 1000 cycles → checker confirms gnt one-hot-or-zero, sel matches gnt, dout equals din[idx] delayed one cycle, and no requester waits more than 3×MAX_HOLD+3 cycles.
